// File: rtl/regfile_np.sv
// regfile_np: parametrised two-read/one-write register file with optional
// write-through bypass, hardwired-zero r0 and a sequential fill engine.
module regfile_np #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter bit ZERO_R0 = 1'b0,
   parameter bit BYPASS  = 1'b1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    ra0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] rd0,
   output logic [WIDTH-1:0] rd1,
   input  logic             fill_req,
   input  logic [WIDTH-1:0] fill_val,
   output logic             busy,
   output logic             done,
   output logic             wr_err
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] fval_q, fval_d;
   logic             done_q, done_d;
   logic             werr_q, werr_d;
   logic             wr_acc, wr_hit, fill_hit;

   always_ff @(posedge clk) begin
      if (clr) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (fill_req)      state_d = S_FILL;
         S_FILL: if (idx_q == LAST) state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == S_FILL);
      done   = done_q;
      wr_err = werr_q;
   end

   // A ZERO_R0 write to r0 is accepted but must never reach storage or bypass.
   assign wr_acc   = we & ~busy;
   assign wr_hit   = wr_acc & ~(ZERO_R0 && (waddr == '0));
   assign fill_hit = busy & ~(ZERO_R0 && (idx_q == '0));

   always_comb begin
      mem_d  = mem_q;
      idx_d  = idx_q;
      fval_d = fval_q;
      if (wr_hit)   mem_d[waddr] = wdata;
      if (fill_hit) mem_d[idx_q] = fval_q;
      if (busy) begin
         idx_d = idx_q + 1'b1;
      end else if (fill_req) begin
         idx_d  = '0;
         fval_d = fill_val;
      end
      done_d = busy && (idx_q == LAST);
      werr_d = we & busy;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         idx_q  <= '0;
         fval_q <= '0;
         done_q <= 1'b0;
         werr_q <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         idx_q  <= idx_d;
         fval_q <= fval_d;
         done_q <= done_d;
         werr_q <= werr_d;
      end
   end

   always_comb begin
      rd0 = mem_q[ra0];
      if (BYPASS && wr_hit && (waddr == ra0)) rd0 = wdata;
      if (ZERO_R0 && (ra0 == '0))             rd0 = '0;
   end

   always_comb begin
      rd1 = mem_q[ra1];
      if (BYPASS && wr_hit && (waddr == ra1)) rd1 = wdata;
      if (ZERO_R0 && (ra1 == '0))             rd1 = '0;
   end

endmodule
